// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - state encoding and shared constants for the DMA bus controller
package dma_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_BEGIN,
        ST_RD_BEAT,
        ST_WR_PREFETCH,
        ST_WR_BEAT,
        ST_WR_END,
        ST_FLUSH,
        ST_ERR
    } dma_state_e;

    localparam int         DMA_MAX_BURST   = 256;
    localparam logic [3:0] DMA_BYTE_EN_ALL = 4'hF;
    localparam int         DMA_LEN_W       = 9;
    localparam int         DMA_BLK_W       = 10;

    // States in which the controller owns (or is asking for) the bus.
    function automatic logic is_bus_state(input dma_state_e s);
        return s inside {ST_REQ, ST_BEGIN, ST_RD_BEAT, ST_WR_PREFETCH, ST_WR_BEAT, ST_WR_END};
    endfunction

    function automatic logic is_xfer_state(input dma_state_e s);
        return s inside {ST_BEGIN, ST_RD_BEAT, ST_WR_PREFETCH, ST_WR_BEAT, ST_WR_END};
    endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// rtl/dma_burst_calc.sv - burst length and post-burst address/count arithmetic
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int MEM_AW    = 9,
    parameter int MAX_BURST = DMA_MAX_BURST
) (
    input  logic [DMA_BLK_W-1:0] remaining,
    input  logic [7:0]           burst_cfg,
    input  logic [31:0]          bus_addr,
    input  logic [MEM_AW-1:0]    mem_addr,
    output logic [DMA_LEN_W-1:0] burst_len,
    output logic [DMA_BLK_W-1:0] next_remaining,
    output logic [31:0]          next_bus_addr,
    output logic [MEM_AW-1:0]    next_mem_addr,
    output logic                 last_burst
);

    localparam logic [DMA_LEN_W-1:0] CAP =
        (MAX_BURST >= 256) ? 9'd256 : DMA_LEN_W'(MAX_BURST);

    logic [DMA_LEN_W-1:0] req_len;
    logic [DMA_LEN_W-1:0] len_a;

    always_comb begin
        req_len = {1'b0, burst_cfg} + DMA_LEN_W'(1);
        len_a   = (remaining < {1'b0, req_len}) ? remaining[DMA_LEN_W-1:0] : req_len;
        burst_len = (len_a < CAP) ? len_a : CAP;
    end

    // Both addresses wrap naturally at their own widths.
    assign next_remaining = remaining - {1'b0, burst_len};
    assign next_bus_addr  = bus_addr + {21'd0, burst_len, 2'b00};
    assign next_mem_addr  = mem_addr + MEM_AW'(burst_len);
    assign last_burst     = (next_remaining == '0);

endmodule

// File: rtl/dma_bus_controller.sv
// rtl/dma_bus_controller.sv - burst DMA engine between a system bus and a scratch memory
module dma_bus_controller
    import dma_pkg::*;
#(
    parameter int MEM_AW    = 9,
    parameter int MAX_BURST = DMA_MAX_BURST
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 direction,
    input  logic [31:0]          bus_start_addr,
    input  logic [MEM_AW-1:0]    mem_start_addr,
    input  logic [9:0]           block_size,
    input  logic [7:0]           burst_size,
    output logic                 busy,
    output logic                 error,
    output logic [MEM_AW-1:0]    mem_addr,
    output logic                 mem_we,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    output logic                 bus_request,
    input  logic                 bus_grant,
    output logic                 bus_begin,
    output logic [31:0]          bus_addr_data,
    output logic                 bus_read_n_write,
    output logic [3:0]           bus_byte_en,
    output logic [7:0]           bus_burst_size,
    output logic                 bus_data_valid_out,
    output logic                 bus_end,
    input  logic [31:0]          bus_data_in,
    input  logic                 bus_data_valid_in,
    input  logic                 bus_end_in,
    input  logic                 bus_error_in,
    input  logic                 bus_busy_in
);

    dma_state_e           state_q, state_d;
    logic                 dir_q, dir_d;
    logic [31:0]          bus_addr_q, bus_addr_d;
    logic [MEM_AW-1:0]    mem_base_q, mem_base_d;
    logic [MEM_AW-1:0]    cur_mem_q, cur_mem_d;
    logic [DMA_BLK_W-1:0] remaining_q, remaining_d;
    logic [7:0]           burst_cfg_q, burst_cfg_d;
    logic [DMA_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic                 error_q, error_d;
    logic                 busy_q, busy_d;
    logic                 bus_request_q, bus_request_d;
    logic                 bus_begin_q, bus_begin_d;
    logic                 bus_end_q, bus_end_d;
    logic                 rnw_q, rnw_d;
    logic                 valid_out_q, valid_out_d;
    logic [3:0]           byte_en_q, byte_en_d;
    logic [7:0]           bsize_q, bsize_d;

    logic [DMA_LEN_W-1:0] burst_len;
    logic [DMA_BLK_W-1:0] next_remaining;
    logic [31:0]          next_bus_addr;
    logic [MEM_AW-1:0]    next_mem_addr;
    logic                 last_burst;
    logic                 advance;

    dma_burst_calc #(
        .MEM_AW    (MEM_AW),
        .MAX_BURST (MAX_BURST)
    ) u_burst_calc (
        .remaining      (remaining_q),
        .burst_cfg      (burst_cfg_q),
        .bus_addr       (bus_addr_q),
        .mem_addr       (mem_base_q),
        .burst_len      (burst_len),
        .next_remaining (next_remaining),
        .next_bus_addr  (next_bus_addr),
        .next_mem_addr  (next_mem_addr),
        .last_burst     (last_burst)
    );

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        bus_addr_d  = bus_addr_q;
        mem_base_d  = mem_base_q;
        cur_mem_d   = cur_mem_q;
        remaining_d = remaining_q;
        burst_cfg_d = burst_cfg_q;
        beat_cnt_d  = beat_cnt_q;
        error_d     = error_q;
        advance     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && block_size != '0) begin
                    state_d     = ST_REQ;
                    dir_d       = direction;
                    bus_addr_d  = bus_start_addr & 32'hFFFF_FFFC;
                    mem_base_d  = mem_start_addr;
                    cur_mem_d   = mem_start_addr;
                    remaining_d = block_size;
                    burst_cfg_d = burst_size;
                    error_d     = 1'b0;
                end
            end
            ST_REQ: begin
                if (bus_grant) state_d = ST_BEGIN;
            end
            ST_BEGIN: begin
                beat_cnt_d = '0;
                state_d    = dir_q ? ST_WR_PREFETCH : ST_RD_BEAT;
            end
            ST_RD_BEAT: begin
                if (bus_data_valid_in) cur_mem_d = cur_mem_q + MEM_AW'(1);
                if (bus_end_in) advance = 1'b1;
            end
            ST_WR_PREFETCH: begin
                state_d = ST_WR_BEAT;
            end
            ST_WR_BEAT: begin
                if (!bus_busy_in) begin
                    cur_mem_d  = cur_mem_q + MEM_AW'(1);
                    beat_cnt_d = beat_cnt_q + DMA_LEN_W'(1);
                    if (beat_cnt_q == burst_len - DMA_LEN_W'(1)) state_d = ST_WR_END;
                end
            end
            ST_WR_END: begin
                advance = 1'b1;
            end
            ST_FLUSH: begin
                state_d = ST_REQ;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A short read burst still consumes its whole window of addresses.
        if (advance) begin
            remaining_d = next_remaining;
            bus_addr_d  = next_bus_addr;
            mem_base_d  = next_mem_addr;
            cur_mem_d   = next_mem_addr;
            state_d     = last_burst ? ST_IDLE : ST_FLUSH;
        end

        if (is_bus_state(state_q) && bus_error_in) begin
            state_d = ST_ERR;
            error_d = 1'b1;
        end

        busy_d        = (state_d != ST_IDLE);
        bus_request_d = is_bus_state(state_d);
        bus_begin_d   = (state_d == ST_BEGIN);
        byte_en_d     = bus_begin_d ? DMA_BYTE_EN_ALL : 4'h0;
        rnw_d         = is_xfer_state(state_d) && !dir_d;
        bsize_d       = is_xfer_state(state_d) ? 8'(burst_len - DMA_LEN_W'(1)) : 8'h00;
        valid_out_d   = (state_d == ST_WR_BEAT);
        bus_end_d     = (state_d == ST_WR_END);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            dir_q         <= 1'b0;
            bus_addr_q    <= '0;
            mem_base_q    <= '0;
            cur_mem_q     <= '0;
            remaining_q   <= '0;
            burst_cfg_q   <= '0;
            beat_cnt_q    <= '0;
            error_q       <= 1'b0;
            busy_q        <= 1'b0;
            bus_request_q <= 1'b0;
            bus_begin_q   <= 1'b0;
            bus_end_q     <= 1'b0;
            rnw_q         <= 1'b0;
            valid_out_q   <= 1'b0;
            byte_en_q     <= '0;
            bsize_q       <= '0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            bus_addr_q    <= bus_addr_d;
            mem_base_q    <= mem_base_d;
            cur_mem_q     <= cur_mem_d;
            remaining_q   <= remaining_d;
            burst_cfg_q   <= burst_cfg_d;
            beat_cnt_q    <= beat_cnt_d;
            error_q       <= error_d;
            busy_q        <= busy_d;
            bus_request_q <= bus_request_d;
            bus_begin_q   <= bus_begin_d;
            bus_end_q     <= bus_end_d;
            rnw_q         <= rnw_d;
            valid_out_q   <= valid_out_d;
            byte_en_q     <= byte_en_d;
            bsize_q       <= bsize_d;
        end
    end

    // Read beats land in memory the same cycle; a write stall keeps the current word addressed.
    assign mem_we    = (state_q == ST_RD_BEAT) && bus_data_valid_in && !bus_error_in;
    assign mem_wdata = mem_we ? bus_data_in : 32'h0;
    assign mem_addr  = (state_q == ST_WR_BEAT && !bus_busy_in) ? cur_mem_q + MEM_AW'(1) : cur_mem_q;

    assign busy               = busy_q;
    assign error              = error_q;
    assign bus_request        = bus_request_q;
    assign bus_begin          = bus_begin_q;
    assign bus_addr_data      = bus_begin_q ? bus_addr_q : (valid_out_q ? mem_rdata : 32'h0);
    assign bus_read_n_write   = rnw_q;
    assign bus_byte_en        = byte_en_q;
    assign bus_burst_size     = bsize_q;
    assign bus_data_valid_out = valid_out_q;
    assign bus_end            = bus_end_q;

endmodule

// File: tb/tb_dma_bus_controller.sv
// tb/tb_dma_bus_controller.sv - self-checking bench for dma_bus_controller
module tb_dma_bus_controller;

    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          direction = 1'b0;
    logic [31:0]   bus_start_addr = '0;
    logic [AW-1:0] mem_start_addr = '0;
    logic [9:0]    block_size = '0;
    logic [7:0]    burst_size = '0;
    logic          busy, error;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          bus_request;
    logic          bus_grant = 1'b0;
    logic          bus_begin;
    logic [31:0]   bus_addr_data;
    logic          bus_read_n_write;
    logic [3:0]    bus_byte_en;
    logic [7:0]    bus_burst_size;
    logic          bus_data_valid_out;
    logic          bus_end;
    logic [31:0]   bus_data_in = '0;
    logic          bus_data_valid_in = 1'b0;
    logic          bus_end_in = 1'b0;
    logic          bus_error_in = 1'b0;
    logic          bus_busy_in = 1'b0;

    logic [31:0]   ram     [DEPTH];
    logic [31:0]   ref_ram [DEPTH];
    logic [92:0]   out_vec;
    int            n_total = 0;
    int            n_pass  = 0;
    int            n_fail  = 0;
    int            n;

    dma_bus_controller #(.MEM_AW(AW), .MAX_BURST(256)) dut (
        .clock(clock), .reset(reset), .start(start), .direction(direction),
        .bus_start_addr(bus_start_addr), .mem_start_addr(mem_start_addr),
        .block_size(block_size), .burst_size(burst_size), .busy(busy), .error(error),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .bus_request(bus_request), .bus_grant(bus_grant), .bus_begin(bus_begin),
        .bus_addr_data(bus_addr_data), .bus_read_n_write(bus_read_n_write),
        .bus_byte_en(bus_byte_en), .bus_burst_size(bus_burst_size),
        .bus_data_valid_out(bus_data_valid_out), .bus_end(bus_end),
        .bus_data_in(bus_data_in), .bus_data_valid_in(bus_data_valid_in),
        .bus_end_in(bus_end_in), .bus_error_in(bus_error_in), .bus_busy_in(bus_busy_in)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    assign out_vec = {busy, error, mem_addr, mem_we, mem_wdata, bus_request, bus_begin,
                      bus_addr_data, bus_read_n_write, bus_byte_en, bus_burst_size,
                      bus_data_valid_out, bus_end};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_xfer(input bit dir, input logic [31:0] ba, input logic [AW-1:0] ma,
                              input int blk, input int bs);
        @(posedge clock); #1;
        start = 1'b1; direction = dir; bus_start_addr = ba; mem_start_addr = ma;
        block_size = 10'(blk); burst_size = 8'(bs);
        @(posedge clock); #1;
        start = 1'b0; direction = ~dir; bus_start_addr = $urandom;
        mem_start_addr = AW'($urandom); block_size = 10'($urandom); burst_size = 8'($urandom);
        @(negedge clock);
    endtask

    task automatic wait_request(input string tag);
        int k = 0;
        @(negedge clock);
        while (!bus_request && k < 20) begin
            @(negedge clock);
            k++;
        end
        check(tag, bus_request, 1'b1);
    endtask

    task automatic grant_and_begin(input logic [31:0] a, input int len, input bit rd);
        @(posedge clock); #1 bus_grant = 1'b1;
        @(posedge clock); #1 bus_grant = 1'b0;
        @(negedge clock);
        check("begin_ctl", {bus_begin, bus_byte_en, bus_read_n_write}, {1'b1, 4'hF, rd});
        check("begin_addr", bus_addr_data, a);
        check("burst_size", bus_burst_size, 8'(len - 1));
    endtask

    task automatic serve_read(input logic [31:0] a, input int len, input logic [AW-1:0] m,
                              input int err_beat, input bit last);
        logic [31:0] d;
        wait_request("rd_request");
        grant_and_begin(a, len, 1'b1);
        for (int i = 0; i < len; i++) begin
            @(posedge clock); #1;
            if (i == err_beat) begin
                bus_error_in = 1'b1;
                @(posedge clock); #1 bus_error_in = 1'b0;
                @(negedge clock);
                check("err_state", {error, bus_request, mem_we}, 3'b100);
                @(negedge clock);
                check("err_idle", {busy, error, bus_request}, 3'b010);
                return;
            end
            d = $urandom;
            bus_data_valid_in = 1'b1; bus_data_in = d; bus_end_in = (i == len - 1);
            ref_ram[m + AW'(i)] = d;
            @(negedge clock);
            check("rd_beat", {mem_we, mem_addr, mem_wdata}, {1'b1, m + AW'(i), d});
        end
        @(posedge clock); #1 bus_data_valid_in = 1'b0; bus_end_in = 1'b0;
        @(negedge clock);
        check("rd_after", {busy, bus_request, mem_we}, {~last, 2'b00});
    endtask

    task automatic serve_write(input logic [31:0] a, input int len, input logic [AW-1:0] m,
                               input int stall_at, input bit last);
        int got = 0;
        int stalled = 0;
        int guard = 0;
        wait_request("wr_request");
        grant_and_begin(a, len, 1'b0);
        while (got < len && guard < 40) begin
            @(posedge clock); #1;
            guard++;
            bus_busy_in = bus_data_valid_out && got == stall_at && stalled < 3;
            if (bus_busy_in) stalled++;
            @(negedge clock);
            if (bus_data_valid_out) begin
                check("wr_data", bus_addr_data, ref_ram[m + AW'(got)]);
                if (!bus_busy_in) got++;
            end
        end
        check("wr_beats", got, len);
        @(posedge clock); #1 bus_busy_in = 1'b0;
        @(negedge clock);
        check("wr_end", {bus_end, bus_data_valid_out, bus_request}, 3'b101);
        @(negedge clock);
        check("wr_after", {busy, bus_request, bus_end}, {~last, 2'b00});
    endtask

    task automatic run_xfer(input bit dir, input logic [31:0] ba, input logic [AW-1:0] ma,
                            input int blk, input int bs, input int stall_at);
        int rem;
        int len;
        logic [31:0] a;
        logic [AW-1:0] m;
        rem = blk;
        a = ba & 32'hFFFF_FFFC;
        m = ma;
        start_xfer(dir, ba, ma, blk, bs);
        check("busy_start", {busy, error}, 2'b10);
        while (rem > 0) begin
            len = (bs + 1 < rem) ? bs + 1 : rem;
            if (dir) serve_write(a, len, m, stall_at, rem == len);
            else     serve_read(a, len, m, -1, rem == len);
            rem -= len;
            a += 32'(4 * len);
            m += AW'(len);
        end
        for (int i = 0; i < blk; i++) check("ram", ram[ma + AW'(i)], ref_ram[ma + AW'(i)]);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = $urandom;
            ref_ram[i] = ram[i];
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", out_vec, '0);
        @(posedge clock); #1 reset = 1'b0;

        start_xfer(1'b0, 32'h0000_2000, 9'h000, 0, 3);
        for (int i = 0; i < 4; i++) begin
            check("zero_block", {busy, bus_request}, 2'b00);
            @(negedge clock);
        end

        run_xfer(1'b0, 32'h0000_1000, 9'h000, 8, 3, -1);
        run_xfer(1'b1, 32'h0000_2002, 9'h1FE, 5, 3, -1);
        run_xfer(1'b1, 32'h0000_4000, 9'h040, 8, 3, 2);

        start_xfer(1'b0, 32'h0000_3000, 9'h100, 8, 3);
        check("err_busy_start", busy, 1'b1);
        serve_read(32'h0000_3000, 4, 9'h100, 1, 1'b0);
        check("err_first_word", ram[9'h100], ref_ram[9'h100]);

        for (int r = 0; r < 6; r++)
            run_xfer(1'($urandom_range(0, 1)), $urandom, AW'($urandom),
                     int'($urandom_range(1, 40)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 4)) - 1);

        start_xfer(1'b1, 32'h0000_8000, 9'h010, 8, 7);
        wait_request("rst_request");
        grant_and_begin(32'h0000_8000, 8, 1'b0);
        n = 0;
        while (!bus_data_valid_out && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("rst_in_wr_beat", bus_data_valid_out, 1'b1);
        @(posedge clock); #1 reset = 1'b1; bus_busy_in = 1'b1;
        @(posedge clock); #1 reset = 1'b0; bus_busy_in = 1'b0;
        @(negedge clock);
        check("rst_abort", out_vec, '0);
        run_xfer(1'b1, 32'h0000_8000, 9'h010, 8, 7, -1);
        run_xfer(1'b0, 32'h0000_9000, 9'h080, 6, 15, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
